money_credit_unit: RTL and testbench

Parametrised deposit-and-credit engine for the vending datapath. It replaces the fixed three-input $1/$5/$10 money decoder with N denomination channels, each with edge detection, and adds a saturating credit register, purchase debit, and greedy coin-by-coin change return. It sits between the debounced deposit buttons and the product-select/display logic.

---
 rtl/money_credit_unit.sv | 197 +++++++++++++++++++
 tb/tb_money_credit_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/money_credit_unit.sv
// ============================================================================
// Module   : money_credit_unit
// Purpose  : N-channel deposit edge detection, saturating credit register,
//            purchase debit, and greedy coin-by-coin change return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module money_credit_unit #(
   parameter int                  NUM_CH     = 3,
   parameter int                  CREDIT_W   = 8,
   parameter logic [NUM_CH*8-1:0] DENOMS     = {8'd10, 8'd5, 8'd1},
   parameter int                  MAX_CREDIT = 99
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   dep_in,
   input  logic                vend_req,
   input  logic [CREDIT_W-1:0] price,
   input  logic                refund_req,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic                dep_accept,
   output logic                dep_reject,
   output logic                vend_ok,
   output logic                vend_deny,
   output logic [NUM_CH-1:0]   coin_out,
   output logic                refund_done
);

   localparam int SUM_W = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
   localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(MAX_CREDIT);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_REFUND = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [NUM_CH-1:0]   dep_prev_q;
   logic                vend_prev_q, refund_prev_q;
   logic                arm_q;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                busy_q, busy_d;
   logic                dep_accept_q, dep_accept_d;
   logic                dep_reject_q, dep_reject_d;
   logic                vend_ok_q, vend_ok_d;
   logic                vend_deny_q, vend_deny_d;
   logic [NUM_CH-1:0]   coin_out_q, coin_out_d;
   logic                refund_done_q, refund_done_d;

   logic [NUM_CH-1:0]   dep_edge;
   logic                vend_edge, refund_edge;
   logic [SUM_W-1:0]    credit_ext, coin_val, dep_val, dep_sum;
   logic [NUM_CH-1:0]   dep_others;
   int                  coin_sel, dep_sel;
   logic                do_coin;

   function automatic logic [SUM_W-1:0] denom_ext(input int idx);
      return SUM_W'(DENOMS[idx*8 +: 8]);
   endfunction

   // Edges are masked for one cycle after reset so a level held through
   // reset is absorbed into the history instead of firing.
   always_comb begin
      dep_edge    = dep_in & ~dep_prev_q & {NUM_CH{arm_q}};
      vend_edge   = vend_req & ~vend_prev_q & arm_q;
      refund_edge = refund_req & ~refund_prev_q & arm_q;
   end

   always_comb begin
      credit_ext = SUM_W'(credit_q);

      coin_sel = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (denom_ext(i) <= credit_ext) coin_sel = i;
      end
      coin_val = denom_ext(coin_sel);

      dep_sel = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (dep_edge[i]) dep_sel = i;
      end
      dep_val = denom_ext(dep_sel);
      dep_sum = credit_ext + dep_val;

      dep_others = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dep_others[i] = dep_edge[i] && (i != dep_sel);
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      busy_d        = 1'b0;
      dep_accept_d  = 1'b0;
      dep_reject_d  = 1'b0;
      vend_ok_d     = 1'b0;
      vend_deny_d   = 1'b0;
      coin_out_d    = '0;
      refund_done_d = 1'b0;
      do_coin       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (refund_edge) begin
               dep_reject_d = |dep_edge;
               if (credit_q == '0) refund_done_d = 1'b1;
               else                do_coin       = 1'b1;
            end else if (vend_edge) begin
               dep_reject_d = |dep_edge;
               if (credit_q >= price) begin
                  credit_d  = credit_q - price;
                  vend_ok_d = 1'b1;
               end else begin
                  vend_deny_d = 1'b1;
               end
            end else if (|dep_edge) begin
               if (dep_sum <= MAX_EXT) begin
                  credit_d     = CREDIT_W'(dep_sum);
                  dep_accept_d = 1'b1;
                  dep_reject_d = |dep_others;
               end else begin
                  dep_reject_d = 1'b1;
               end
            end
         end
         default: begin
            dep_reject_d = |dep_edge;
            if (credit_q == '0) begin
               refund_done_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               do_coin = 1'b1;
            end
         end
      endcase

      // The first coin goes out in the same cycle the refund edge is seen.
      if (do_coin) begin
         for (int i = 0; i < NUM_CH; i++) begin
            coin_out_d[i] = (i == coin_sel);
         end
         credit_d = CREDIT_W'(credit_ext - coin_val);
         busy_d   = 1'b1;
         if (credit_ext == coin_val) begin
            refund_done_d = 1'b1;
            state_d       = ST_IDLE;
         end else begin
            state_d = ST_REFUND;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         dep_prev_q    <= '0;
         vend_prev_q   <= 1'b0;
         refund_prev_q <= 1'b0;
         arm_q         <= 1'b0;
         credit_q      <= '0;
         busy_q        <= 1'b0;
         dep_accept_q  <= 1'b0;
         dep_reject_q  <= 1'b0;
         vend_ok_q     <= 1'b0;
         vend_deny_q   <= 1'b0;
         coin_out_q    <= '0;
         refund_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dep_prev_q    <= dep_in;
         vend_prev_q   <= vend_req;
         refund_prev_q <= refund_req;
         arm_q         <= 1'b1;
         credit_q      <= credit_d;
         busy_q        <= busy_d;
         dep_accept_q  <= dep_accept_d;
         dep_reject_q  <= dep_reject_d;
         vend_ok_q     <= vend_ok_d;
         vend_deny_q   <= vend_deny_d;
         coin_out_q    <= coin_out_d;
         refund_done_q <= refund_done_d;
      end
   end

   assign credit      = credit_q;
   assign busy        = busy_q;
   assign dep_accept  = dep_accept_q;
   assign dep_reject  = dep_reject_q;
   assign vend_ok     = vend_ok_q;
   assign vend_deny   = vend_deny_q;
   assign coin_out    = coin_out_q;
   assign refund_done = refund_done_q;

endmodule

`default_nettype wire

// File: tb/tb_money_credit_unit.sv
// ============================================================================
// Module   : tb_money_credit_unit
// Purpose  : Directed self-checking bench for money_credit_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_money_credit_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] dep_in = '0;
   logic       vend_req = 1'b0;
   logic [7:0] price = '0;
   logic       refund_req = 1'b0;
   logic [7:0] credit;
   logic       busy, dep_accept, dep_reject, vend_ok, vend_deny, refund_done;
   logic [2:0] coin_out;

   int n_cmp = 0;
   int n_err = 0;

   money_credit_unit dut (
      .clk         (clk),
      .reset       (reset),
      .dep_in      (dep_in),
      .vend_req    (vend_req),
      .price       (price),
      .refund_req  (refund_req),
      .credit      (credit),
      .busy        (busy),
      .dep_accept  (dep_accept),
      .dep_reject  (dep_reject),
      .vend_ok     (vend_ok),
      .vend_deny   (vend_deny),
      .coin_out    (coin_out),
      .refund_done (refund_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int ch, output logic acc, output logic rej);
      dep_in[ch] = 1'b1;
      cyc();
      acc = dep_accept;
      rej = dep_reject;
      dep_in = '0;
      cyc();
   endtask

   logic acc, rej;
   int   exp_coin [5] = '{4, 4, 2, 1, 1};

   initial begin
      cyc();
      cyc();
      check_val("rst_credit", credit, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_coin", coin_out, 0);
      check_val("rst_done", refund_done, 0);
      reset = 1'b0;
      cyc();
      cyc();

      // Refund with zero credit completes at once
      refund_req = 1'b1;
      cyc();
      check_val("refund0_done", refund_done, 1);
      check_val("refund0_busy", busy, 0);
      refund_req = 1'b0;
      cyc();
      check_val("refund0_pulse", refund_done, 0);

      // One deposit per channel
      dep_in = 3'b001;
      cyc();
      check_val("dep1_acc", dep_accept, 1);
      check_val("dep1_credit", credit, 1);
      dep_in = '0;
      cyc();
      check_val("dep1_pulse", dep_accept, 0);
      press(1, acc, rej);
      check_val("dep5_acc", acc, 1);
      check_val("dep5_credit", credit, 6);
      press(2, acc, rej);
      check_val("dep10_acc", acc, 1);
      check_val("dep10_credit", credit, 16);

      // Purchases
      vend_req = 1'b1;
      price = 8'd12;
      cyc();
      check_val("vend12_ok", vend_ok, 1);
      check_val("vend12_credit", credit, 4);
      vend_req = 1'b0;
      cyc();
      check_val("vend_pulse", vend_ok, 0);
      vend_req = 1'b1;
      price = 8'd7;
      cyc();
      check_val("vend7_deny", vend_deny, 1);
      check_val("vend7_ok", vend_ok, 0);
      check_val("vend7_credit", credit, 4);
      vend_req = 1'b0;
      cyc();

      // Climb to 95 then test the ceiling
      for (int i = 0; i < 9; i++) press(2, acc, rej);
      press(0, acc, rej);
      check_val("credit95", credit, 95);
      press(1, acc, rej);
      check_val("ceil5_rej", rej, 1);
      check_val("ceil5_acc", acc, 0);
      check_val("ceil5_credit", credit, 95);
      for (int i = 0; i < 4; i++) press(0, acc, rej);
      check_val("credit99", credit, 99);
      press(0, acc, rej);
      check_val("ceil1_rej", rej, 1);
      check_val("ceil1_credit", credit, 99);

      // Refund of 27: 10,10,5,1,1
      vend_req = 1'b1;
      price = 8'd72;
      cyc();
      vend_req = 1'b0;
      cyc();
      check_val("credit27", credit, 27);
      refund_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         refund_req = 1'b0;
         check_val("refund_coin", coin_out, exp_coin[k]);
         check_val("refund_busy", busy, 1);
         check_val("refund_done", refund_done, (k == 4) ? 1 : 0);
      end
      check_val("refund_credit", credit, 0);
      cyc();
      check_val("refund_busy_off", busy, 0);
      check_val("refund_coin_off", coin_out, 0);

      // Simultaneous deposits
      dep_in = 3'b110;
      cyc();
      check_val("simul_acc", dep_accept, 1);
      check_val("simul_rej", dep_reject, 1);
      check_val("simul_credit", credit, 5);
      dep_in = '0;
      cyc();

      // Deposit pre-empted by vend of price 0
      dep_in = 3'b001;
      vend_req = 1'b1;
      price = 8'd0;
      cyc();
      check_val("pre_vend_ok", vend_ok, 1);
      check_val("pre_dep_rej", dep_reject, 1);
      check_val("pre_dep_acc", dep_accept, 0);
      check_val("pre_credit", credit, 5);
      dep_in = '0;
      vend_req = 1'b0;
      cyc();

      // Reset in the second coin cycle of a 27 refund
      press(2, acc, rej);
      press(2, acc, rej);
      press(0, acc, rej);
      press(0, acc, rej);
      check_val("credit27b", credit, 27);
      refund_req = 1'b1;
      cyc();
      refund_req = 1'b0;
      dep_in = 3'b010;
      cyc();
      check_val("mid_coin", coin_out, 4);
      check_val("mid_credit", credit, 7);
      check_val("mid_rej", dep_reject, 1);
      #2 reset = 1'b1;
      #1;
      check_val("async_credit", credit, 0);
      check_val("async_busy", busy, 0);
      check_val("async_coin", coin_out, 0);
      #2 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_val("held_acc", dep_accept, 0);
         check_val("held_credit", credit, 0);
      end
      dep_in = '0;
      cyc();
      press(1, acc, rej);
      check_val("repress_acc", acc, 1);
      check_val("repress_credit", credit, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
